// File: rtl/seq_divider_if.sv
// Request/response bundle for seq_divider: operands and start in, results, flags and status out.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             dz;
    logic             of;

    modport master (
        output start, sgn, dividend, divisor,
        input  busy, done, quotient, remainder, dz, of
    );

    modport slave (
        input  start, sgn, dividend, divisor,
        output busy, done, quotient, remainder, dz, of
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, signed/unsigned; WIDTH+1 cycles start-to-done, 1 cycle on divide-by-zero/overflow.
// No backpressure: start is only taken while idle, results are held until the next accepted start.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r, quo_r, dvs_mag;
    logic             neg_q, neg_r, exc_dz, exc_of;
    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic             done_r, dz_r, of_r;

    logic             accept, last_iter;
    logic             dvd_neg_in, dvs_neg_in, dz_in, of_in;
    logic [WIDTH-1:0] dvd_mag_in, dvs_mag_in;
    logic [WIDTH:0]   trial;

    always_comb begin
        dvd_neg_in = bus.sgn & bus.dividend[WIDTH-1];
        dvs_neg_in = bus.sgn & bus.divisor[WIDTH-1];
        dvd_mag_in = dvd_neg_in ? -bus.dividend : bus.dividend;
        dvs_mag_in = dvs_neg_in ? -bus.divisor : bus.divisor;
        dz_in      = (bus.divisor == '0);
        of_in      = bus.sgn && (bus.dividend == MIN_VAL) && (bus.divisor == '1);
        // Shifted partial remainder is WIDTH+1 bits; bit WIDTH of the difference is the borrow.
        trial      = {rem_r, quo_r[WIDTH-1]} - {1'b0, dvs_mag};
        last_iter  = (cnt == CW'(WIDTH-1));
        accept     = 1'b0;
        state_nxt  = state;
        case (state)
            IDLE: if (bus.start) begin
                accept    = 1'b1;
                state_nxt = (dz_in || of_in) ? FIX : CALC;
            end
            CALC: if (last_iter) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            dvs_mag     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            exc_dz      <= 1'b0;
            exc_of      <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            done_r      <= 1'b0;
            dz_r        <= 1'b0;
            of_r        <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                cnt     <= '0;
                rem_r   <= '0;
                dvs_mag <= dvs_mag_in;
                neg_q   <= dvd_neg_in ^ dvs_neg_in;
                neg_r   <= dvd_neg_in;
                exc_dz  <= dz_in;
                exc_of  <= of_in;
                // Exceptions report the raw dividend, so keep it unconverted for them.
                quo_r   <= (dz_in || of_in) ? bus.dividend : dvd_mag_in;
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
                if (!trial[WIDTH]) begin
                    rem_r <= trial[WIDTH-1:0];
                    quo_r <= {quo_r[WIDTH-2:0], 1'b1};
                end else begin
                    rem_r <= {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
                    quo_r <= {quo_r[WIDTH-2:0], 1'b0};
                end
            end else if (state == FIX) begin
                done_r <= 1'b1;
                dz_r   <= exc_dz;
                of_r   <= exc_of;
                if (exc_dz) begin
                    quotient_r  <= '1;
                    remainder_r <= quo_r;
                end else if (exc_of) begin
                    quotient_r  <= quo_r;
                    remainder_r <= '0;
                end else begin
                    quotient_r  <= neg_q ? -quo_r : quo_r;
                    remainder_r <= neg_r ? -rem_r : rem_r;
                end
            end
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_r;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.dz        = dz_r;
    assign bus.of        = of_r;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=32) with hand-computed quotients, remainders, flags and latencies.
module tb_seq_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seq_divider_if #(.WIDTH(32)) bus ();
    seq_divider #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for exactly one edge (E0) and returns just after it.
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        bus.sgn      = s;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (!bus.done && lat < 200) begin
            tick();
            lat++;
            if (bus.busy) busy_cnt++;
        end
    endtask

    task automatic check_res(input string tag, input logic [31:0] q, input logic [31:0] r,
                             input logic dz, input logic of, input int exp_lat, input int lat);
        check({tag, " lat"},  64'(lat),   64'(exp_lat));
        check({tag, " done"}, 64'(bus.done), 64'd1);
        check({tag, " busy"}, 64'(bus.busy), 64'd0);
        check({tag, " q"},    64'(bus.quotient),  64'(q));
        check({tag, " r"},    64'(bus.remainder), 64'(r));
        check({tag, " dz"},   64'(bus.dz), 64'(dz));
        check({tag, " of"},   64'(bus.of), 64'(of));
    endtask

    task automatic run(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r, input logic dz, input logic of,
                       input int exp_lat);
        int lat, bc;
        launch(s, a, b);
        check({tag, " busy@E0"}, 64'(bus.busy), 64'd1);
        wait_done(lat, bc);
        check_res(tag, q, r, dz, of, exp_lat, lat);
        check({tag, " busy cycles"}, 64'(bc + 1), 64'(exp_lat));
        tick();
        check({tag, " done pulse"}, 64'(bus.done), 64'd0);
        check({tag, " q held"}, 64'(bus.quotient), 64'(q));
    endtask

    initial begin
        int lat, bc, pulses;
        bus.start    = 1'b0;
        bus.sgn      = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        tick();
        tick();
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst done", 64'(bus.done), 64'd0);
        check("rst q",    64'(bus.quotient), 64'd0);
        check("rst r",    64'(bus.remainder), 64'd0);
        check("rst dz",   64'(bus.dz), 64'd0);
        check("rst of",   64'(bus.of), 64'd0);
        rst = 1'b0;
        tick();

        run("u dz",     1'b0, 32'h12345678, 32'h0,        32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0, 1);
        run("u 100/7",  1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 33);
        run("s of",     1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b0, 1'b1, 1);
        run("s -100/7", 1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 33);
        run("s 100/-7", 1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 1'b0, 33);
        run("s -100/-7",1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0, 33);
        run("u max/1",  1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 33);
        run("u min/max",1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 1'b0, 33);
        run("s -5/0",   1'b1, 32'hFFFFFFFB, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1'b0, 1);

        // A start at E5 of a running operation must be ignored.
        launch(1'b0, 32'd1000, 32'd10);
        repeat (4) tick();
        bus.dividend = 32'd7;
        bus.divisor  = 32'd0;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        check("ign busy", 64'(bus.busy), 64'd1);
        wait_done(lat, bc);
        check_res("ign", 32'd100, 32'd0, 1'b0, 1'b0, 28, lat);

        // Start in the done cycle is accepted without a gap.
        launch(1'b0, 32'd77, 32'd5);
        check("b2b busy", 64'(bus.busy), 64'd1);
        check("b2b q held", 64'(bus.quotient), 64'd100);
        wait_done(lat, bc);
        check_res("b2b", 32'd15, 32'd2, 1'b0, 1'b0, 33, lat);
        tick();

        // Reset at E10 aborts the operation and clears outputs.
        launch(1'b0, 32'd100, 32'd7);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort done", 64'(bus.done), 64'd0);
        check("abort q",    64'(bus.quotient), 64'd0);
        check("abort r",    64'(bus.remainder), 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) pulses++;
        end
        check("abort no done", 64'(pulses), 64'd0);
        check("abort idle", 64'(bus.busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
